// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the operand-fetch side of the datapath.
//   - OP_* : barrel-shifter operation codes. barrel_shifter decodes the same
//            values, so the encoding must not change here alone.
//   - state_t : FSM states of shifter_operand_stage.
//   - form_t : the operand-2 encoding class of a data-processing word.
//   - operand_t : decoded shifter operand bundle.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Barrel-shifter operation select. LSL..ROR match the two-bit ARM shift
  // type field with a zero prepended; RRX is the extra encoding.
  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_RRX = 3'b100;

  // Operand stage FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RS   = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Operand-2 encoding classes.
  typedef enum logic [1:0] {
    FORM_IMM       = 2'd0,  // 8-bit immediate rotated by 2*rot
    FORM_IMM_SHIFT = 2'd1,  // Rm shifted by a 5-bit immediate
    FORM_REG_SHIFT = 2'd2,  // Rm shifted by Rs[7:0]
    FORM_ILLEGAL   = 2'd3   // bit4=1 and bit7=1: not an operand-2 encoding
  } form_t;

  // Decoded operand as it will be presented to the barrel shifter.
  typedef struct packed {
    form_t       form;
    logic [31:0] data;
    logic [31:0] value;
    logic [2:0]  op;
    logic        illegal;
  } operand_t;

  // Map the ARM shift-type field onto the shifter op encoding.
  function automatic logic [2:0] type_to_op(input logic [1:0] shift_type);
    return {1'b0, shift_type};
  endfunction

endpackage

// File: rtl/operand_field_decode.sv
// -----------------------------------------------------------------------------
// operand_field_decode
// Purely combinational decode of the operand-2 field of an ARM
// data-processing instruction into barrel-shifter operands.
//
// Ports
//   instr   in  32  instruction word being accepted
//   rm_data in  32  register-file value of Rm (instr[3:0])
//   operand out     decoded form, data, shift value, op and illegal flag
//   rs_addr out  4  Rs register number, used in the second cycle of a
//                   register-specified shift
//
// For the register-shift form the value field is left at 0; the actual
// shift amount arrives one cycle later from the Rs read and is filled in by
// the FSM owner.
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module operand_field_decode (
  input  logic [31:0] instr,
  input  logic [31:0] rm_data,
  output operand_t    operand,
  output logic [3:0]  rs_addr
);

  logic [4:0] shift_imm;
  logic [1:0] shift_type;
  logic [3:0] rot;
  logic [7:0] imm8;
  logic       is_imm;
  logic       is_reg_shift;
  logic       bit7;

  // Condition, opcode, S, Rn and Rd are irrelevant to the operand path.
  logic unused_fields;

  assign shift_imm    = instr[11:7];
  assign shift_type   = instr[6:5];
  assign rot          = instr[11:8];
  assign imm8         = instr[7:0];
  assign is_imm       = instr[25];
  assign is_reg_shift = instr[4];
  assign bit7         = instr[7];
  assign rs_addr      = instr[11:8];
  assign unused_fields = ^{instr[31:26], instr[24:12]};

  always_comb begin
    operand = '0;

    if (is_imm) begin
      // Rotate amount is twice the 4-bit rot field.
      operand.form  = FORM_IMM;
      operand.data  = {24'b0, imm8};
      operand.value = {27'b0, rot, 1'b0};
      operand.op    = OP_ROR;
    end else if (!is_reg_shift) begin
      operand.form = FORM_IMM_SHIFT;
      operand.data = rm_data;
      unique case (shift_type)
        2'b00: begin
          // LSL #0 is a plain passthrough of Rm.
          operand.op    = OP_LSL;
          operand.value = {27'b0, shift_imm};
        end
        2'b01, 2'b10: begin
          // LSR #0 / ASR #0 encode a shift by 32.
          operand.op    = type_to_op(shift_type);
          operand.value = (shift_imm == 5'd0) ? 32'd32 : {27'b0, shift_imm};
        end
        default: begin
          // ROR #0 encodes RRX: rotate right by one through carry.
          if (shift_imm == 5'd0) begin
            operand.op    = OP_RRX;
            operand.value = 32'd1;
          end else begin
            operand.op    = OP_ROR;
            operand.value = {27'b0, shift_imm};
          end
        end
      endcase
    end else if (!bit7) begin
      operand.form = FORM_REG_SHIFT;
      operand.data = rm_data;
      operand.op   = type_to_op(shift_type);
    end else begin
      // Multiply / extra load-store space: flag it and pass Rm unshifted.
      operand.form    = FORM_ILLEGAL;
      operand.data    = rm_data;
      operand.op      = OP_LSL;
      operand.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/shifter_operand_stage.sv
// -----------------------------------------------------------------------------
// shifter_operand_stage
// Pipeline stage that turns an ARM data-processing instruction into the
// operands of the barrel shifter. Reads Rm through a combinational
// register-file port at acceptance and, for register-specified shifts, reads
// Rs in a second cycle.
//
// Ports
//   clk             in   1  rising-edge clock
//   rst_n           in   1  synchronous active-low reset
//   in_valid        in   1  upstream offers an instruction
//   out_ready       out  1  instruction/carry accepted this cycle
//   in_instr        in  32  instruction word
//   in_carry        in   1  CPSR C flag
//   out_rf_addr     out  4  register-file read address
//   in_rf_data      in  32  register-file read data (same cycle)
//   in_flush        in   1  drop any in-flight operand
//   out_valid       out  1  shifter operands valid
//   in_ready        in   1  downstream consumes operands
//   out_shift_data  out 32  shifter data input
//   out_shift_value out 32  shifter shift amount
//   out_op_select   out  3  shifter operation
//   out_carry       out  1  C flag captured at acceptance
//   out_illegal     out  1  accepted word is not an operand-2 encoding
//
// Latency: 1 cycle for immediate / immediate-shift / illegal words, 2 cycles
// for register-specified shifts. With in_ready held high, a new word can be
// accepted in the same cycle the previous result is consumed.
// -----------------------------------------------------------------------------
import cpu_pkg::*;

module shifter_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        out_ready,
  input  logic [31:0] in_instr,
  input  logic        in_carry,
  output logic [3:0]  out_rf_addr,
  input  logic [31:0] in_rf_data,
  input  logic        in_flush,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] out_shift_data,
  output logic [31:0] out_shift_value,
  output logic [2:0]  out_op_select,
  output logic        out_carry,
  output logic        out_illegal
);

  state_t      state_reg;
  state_t      state_next;

  logic [3:0]  rs_addr_reg;
  logic [31:0] data_reg;
  logic [31:0] value_reg;
  logic [2:0]  op_reg;
  logic        carry_reg;
  logic        illegal_reg;

  operand_t    dec_operand;
  logic [3:0]  dec_rs_addr;
  logic        accept;

  // ---------------------------------------------------------------------------
  // Field decode of the word being offered. Rm is read through out_rf_addr,
  // which points at in_instr[3:0] during an acceptance.
  // ---------------------------------------------------------------------------
  operand_field_decode u_decode (
    .instr   (in_instr),
    .rm_data (in_rf_data),
    .operand (dec_operand),
    .rs_addr (dec_rs_addr)
  );

  // ---------------------------------------------------------------------------
  // Handshake. Flush wins over everything except reset, so it also masks
  // out_ready: nothing is taken in the cycle the pipe is being cleared.
  // S_RS never accepts because the read port is busy fetching Rs.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_ready = 1'b0;
    if (!in_flush) begin
      out_ready = (state_reg == S_IDLE) ||
                  ((state_reg == S_OUT) && in_ready);
    end
  end

  assign accept    = in_valid && out_ready;
  assign out_valid = (state_reg == S_OUT);

  // Read port: Rm on acceptance, Rs during S_RS, otherwise parked at 0.
  always_comb begin
    out_rf_addr = 4'd0;
    if (accept) begin
      out_rf_addr = in_instr[3:0];
    end else if (state_reg == S_RS) begin
      out_rf_addr = rs_addr_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = (dec_operand.form == FORM_REG_SHIFT) ? S_RS : S_OUT;
        end
      end
      S_RS: begin
        state_next = S_OUT;
      end
      S_OUT: begin
        if (accept) begin
          state_next = (dec_operand.form == FORM_REG_SHIFT) ? S_RS : S_OUT;
        end else if (in_ready) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (in_flush) begin
      state_next = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // State and operand registers. Operand registers only change on an
  // acceptance or while fetching Rs, so they hold while out_valid is high
  // and downstream stalls. A flush only needs to return to S_IDLE: the
  // stale operand is invisible because out_valid drops.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      rs_addr_reg <= 4'd0;
      data_reg    <= 32'd0;
      value_reg   <= 32'd0;
      op_reg      <= OP_LSL;
      carry_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        rs_addr_reg <= dec_rs_addr;
        data_reg    <= dec_operand.data;
        value_reg   <= dec_operand.value;
        op_reg      <= dec_operand.op;
        carry_reg   <= in_carry;
        illegal_reg <= dec_operand.illegal;
      end else if ((state_reg == S_RS) && !in_flush) begin
        // Register-specified amounts use only the bottom byte of Rs.
        value_reg <= {24'b0, in_rf_data[7:0]};
      end
    end
  end

  assign out_shift_data  = data_reg;
  assign out_shift_value = value_reg;
  assign out_op_select   = op_reg;
  assign out_carry       = carry_reg;
  assign out_illegal     = illegal_reg;

endmodule

// File: tb/tb_shifter_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_shifter_operand_stage
// Directed, table-driven bench for shifter_operand_stage with a small
// register-file model answering the combinational read port.
// -----------------------------------------------------------------------------
module tb_shifter_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic        in_carry;
  logic [3:0]  out_rf_addr;
  logic [31:0] in_rf_data;
  logic        in_flush;
  logic        out_valid;
  logic        in_ready;
  logic [31:0] out_shift_data;
  logic [31:0] out_shift_value;
  logic [2:0]  out_op_select;
  logic        out_carry;
  logic        out_illegal;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [16];
  assign in_rf_data = rf[out_rf_addr];

  shifter_operand_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .out_ready       (out_ready),
    .in_instr        (in_instr),
    .in_carry        (in_carry),
    .out_rf_addr     (out_rf_addr),
    .in_rf_data      (in_rf_data),
    .in_flush        (in_flush),
    .out_valid       (out_valid),
    .in_ready        (in_ready),
    .out_shift_data  (out_shift_data),
    .out_shift_value (out_shift_value),
    .out_op_select   (out_op_select),
    .out_carry       (out_carry),
    .out_illegal     (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic        carry;
    logic [31:0] exp_data;
    logic [31:0] exp_value;
    logic [2:0]  exp_op;
    logic        exp_illegal;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    // instr, carry, data, value, op, illegal, latency
    vecs[0]  = '{32'hE3A004FF, 1'b0, 32'h000000FF, 32'd8,  3'b011, 1'b0, 1}; // imm ror 8
    vecs[1]  = '{32'hE1A00022, 1'b0, 32'h80000000, 32'd32, 3'b001, 1'b0, 1}; // LSR #0
    vecs[2]  = '{32'hE1A00042, 1'b1, 32'h80000000, 32'd32, 3'b010, 1'b0, 1}; // ASR #0
    vecs[3]  = '{32'hE1A00061, 1'b1, 32'h00000003, 32'd1,  3'b100, 1'b0, 1}; // RRX
    vecs[4]  = '{32'hE1A00413, 1'b0, 32'h00000010, 32'h21, 3'b000, 1'b0, 2}; // LSL R4
    vecs[5]  = '{32'hE1A00473, 1'b1, 32'h00000010, 32'h21, 3'b011, 1'b0, 2}; // ROR R4
    vecs[6]  = '{32'hE1A00285, 1'b0, 32'h12345678, 32'd5,  3'b000, 1'b0, 1}; // LSL #5
    vecs[7]  = '{32'hE1A00005, 1'b1, 32'h12345678, 32'd0,  3'b000, 1'b0, 1}; // LSL #0
    vecs[8]  = '{32'hE1A00FE5, 1'b0, 32'h12345678, 32'd31, 3'b011, 1'b0, 1}; // ROR #31
    vecs[9]  = '{32'hE1A000A1, 1'b0, 32'h00000003, 32'd1,  3'b001, 1'b0, 1}; // LSR #1
    vecs[10] = '{32'hE0000091, 1'b1, 32'h00000003, 32'd0,  3'b000, 1'b1, 1}; // illegal
    vecs[11] = '{32'hE3A00F80, 1'b0, 32'h00000080, 32'd30, 3'b011, 1'b0, 1}; // imm rot 15
    vecs[12] = '{32'hE3A00012, 1'b1, 32'h00000012, 32'd0,  3'b011, 1'b0, 1}; // imm rot 0
  end

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = 32'hDEAD0000 | r;
    rf[0] = 32'h0;
    rf[1] = 32'h00000003;
    rf[2] = 32'h80000000;
    rf[3] = 32'h00000010;
    rf[4] = 32'h00000121;
    rf[5] = 32'h12345678;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_instr = 32'h0;
    in_carry = 1'b0;
    in_flush = 1'b0;
    in_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;

    // Reset state.
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", out_shift_data, 32'd0);
    chk("rst_value", out_shift_value, 32'd0);
    chk("rst_op", {29'b0, out_op_select}, 32'd0);
    chk("rst_flags", {30'b0, out_carry, out_illegal}, 32'd0);
    chk("rst_ready", {31'b0, out_ready}, 32'd1);
    chk("rst_addr", {28'b0, out_rf_addr}, 32'd0);
    $display("txn reset released");

    // Table-driven single transactions, each from S_IDLE.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_carry = vecs[i].carry;
      in_ready = 1'b0;
      #1;
      chk("acc_ready", {31'b0, out_ready}, 32'd1);
      chk("acc_addr", {28'b0, out_rf_addr}, {28'b0, vecs[i].instr[3:0]});
      step();
      in_valid = 1'b0;
      in_carry = ~vecs[i].carry;
      #1;
      if (vecs[i].lat == 2) begin
        chk("rs_valid", {31'b0, out_valid}, 32'd0);
        chk("rs_ready", {31'b0, out_ready}, 32'd0);
        chk("rs_addr", {28'b0, out_rf_addr}, {28'b0, vecs[i].instr[11:8]});
        step();
      end
      chk("valid", {31'b0, out_valid}, 32'd1);
      chk("data", out_shift_data, vecs[i].exp_data);
      chk("value", out_shift_value, vecs[i].exp_value);
      chk("op", {29'b0, out_op_select}, {29'b0, vecs[i].exp_op});
      chk("carry", {31'b0, out_carry}, {31'b0, vecs[i].carry});
      chk("illegal", {31'b0, out_illegal}, {31'b0, vecs[i].exp_illegal});
      chk("idle_addr", {28'b0, out_rf_addr}, 32'd0);
      $display("txn vec %0d instr=%08h data=%08h value=%0d op=%0d c=%0b ill=%0b",
               i, vecs[i].instr, out_shift_data, out_shift_value,
               out_op_select, out_carry, out_illegal);
      in_ready = 1'b1;
      step();
      chk("drain_valid", {31'b0, out_valid}, 32'd0);
      in_ready = 1'b0;
    end

    // Back-to-back immediates, zero bubble.
    in_ready = 1'b1;
    in_valid = 1'b1;
    in_carry = 1'b0;
    in_instr = 32'hE3A00011;
    step();
    chk("b2b0_data", out_shift_data, 32'h11);
    chk("b2b0_ready", {31'b0, out_ready}, 32'd1);
    in_instr = 32'hE3A00122;
    step();
    chk("b2b1_valid", {31'b0, out_valid}, 32'd1);
    chk("b2b1_data", out_shift_data, 32'h22);
    chk("b2b1_value", out_shift_value, 32'd2);
    chk("b2b1_ready", {31'b0, out_ready}, 32'd1);
    in_instr = 32'hE3A00233;
    step();
    chk("b2b2_data", out_shift_data, 32'h33);
    chk("b2b2_value", out_shift_value, 32'd4);
    in_valid = 1'b0;
    step();
    chk("b2b_end_valid", {31'b0, out_valid}, 32'd0);
    $display("txn back-to-back immediates done");

    // Downstream stall: outputs frozen, nothing accepted.
    in_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hE3A00144;
    step();
    in_instr = 32'hE3A00255;
    #1;
    chk("stall_ready", {31'b0, out_ready}, 32'd0);
    step();
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_data", out_shift_data, 32'h44);
    chk("stall_value", out_shift_value, 32'd2);
    in_valid = 1'b0;
    in_ready = 1'b1;
    step();
    chk("stall_end_valid", {31'b0, out_valid}, 32'd0);
    $display("txn stall done");

    // Flush during S_RS.
    in_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = 32'hE1A00413;
    step();
    in_valid = 1'b0;
    in_flush = 1'b1;
    #1;
    chk("flush_ready", {31'b0, out_ready}, 32'd0);
    step();
    in_flush = 1'b0;
    #1;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_idle_ready", {31'b0, out_ready}, 32'd1);
    step();
    chk("flush_valid2", {31'b0, out_valid}, 32'd0);
    $display("txn flush in S_RS done");

    // Reset in S_OUT.
    in_valid = 1'b1;
    in_carry = 1'b1;
    in_instr = 32'hE3A004FF;
    step();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_data", out_shift_data, 32'd0);
    chk("mid_rst_value", out_shift_value, 32'd0);
    chk("mid_rst_carry", {31'b0, out_carry}, 32'd0);
    $display("txn reset in S_OUT done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
